// File: rtl/decodificador_pasos_motor.sv
// ---------------------------------------------------------------------------
// decodificador_pasos_motor
//
// Receive side of a unipolar stepper coil interface driven in half-step mode.
// The four coil lines are synchronized, glitch-filtered and decoded into a
// half-step index. Each legal index change updates a signed position counter
// and the rotation direction. Illegal codes and impossible jumps (3, 4 or 5
// half-steps) put the block into a sticky FAULT state that clrErr releases.
//
// Parameters
//   FILTER_CYC  cycles a synchronized pattern must hold to be accepted (>=1)
//   POS_W       width of the signed position counter
//
// Ports
//   clk           in   system clock, single domain
//   rst           in   synchronous active-high reset
//   bobinasMotor  in   coil lines [3]=A [2]=B [1]=C [0]=D, asynchronous
//   clrErr        in   one-cycle pulse, leaves FAULT
//   posicion      out  signed half-step position (wraps, no saturation)
//   pulsoPaso     out  one-cycle pulse per accepted step
//   direccGiro    out  direction of last step, 1 = forward
//   ledDirecc     out  copy of direccGiro
//   errorSec      out  high while in FAULT
//   periodoPaso   out  clk cycles between the last two steps
//
// Build option
//   PERIOD_MEAS_EN  when defined, builds the step period counter; otherwise
//                   periodoPaso is tied to zero.
//
// Latency from a coil change to pulsoPaso/posicion: FILTER_CYC+2 clk edges
// (two synchronizer stages, then the filter accepts on the edge where the
// pattern has been seen FILTER_CYC times). All outputs are registered.
// ---------------------------------------------------------------------------
module decodificador_pasos_motor #(
    parameter int FILTER_CYC = 4,
    parameter int POS_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       bobinasMotor,
    input  logic             clrErr,
    output logic [POS_W-1:0] posicion,
    output logic             pulsoPaso,
    output logic             direccGiro,
    output logic             ledDirecc,
    output logic             errorSec,
    output logic [23:0]      periodoPaso
);

    // state | meaning
    // SYNC  | no reference index yet (after reset, release or clear)
    // TRACK | reference index valid, steps are decoded against it
    // FAULT | illegal code or jump seen, input ignored until clrErr
    localparam logic [1:0] SYNC  = 2'd0;
    localparam logic [1:0] TRACK = 2'd1;
    localparam logic [1:0] FAULT = 2'd2;

    localparam int               CNT_W    = $clog2(FILTER_CYC + 1);
    localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILTER_CYC);
    localparam logic [CNT_W-1:0] FILT_ONE = CNT_W'(1);

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [3:0]       acc_code_q, acc_code_d;
    logic [1:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             pulse_q, pulse_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;

    logic             same, accept, new_code;
    logic [3:0]       dec;
    logic             dec_valid;
    logic [2:0]       dec_idx, diff;
    logic             released;

    // Returns {valid, index} for a coil pattern.
    function automatic logic [3:0] decode_code(input logic [3:0] c);
        logic [3:0] r;
        case (c)
            4'b1000: r = 4'b1_000;
            4'b1100: r = 4'b1_001;
            4'b0100: r = 4'b1_010;
            4'b0110: r = 4'b1_011;
            4'b0010: r = 4'b1_100;
            4'b0011: r = 4'b1_101;
            4'b0001: r = 4'b1_110;
            4'b1001: r = 4'b1_111;
            default: r = 4'b0_000;
        endcase
        decode_code = r;
    endfunction

    // Glitch filter: run_d is the length of the current run of identical
    // synchronized samples, saturating at FILTER_CYC. A pattern is accepted
    // exactly once, on the cycle its run first reaches FILTER_CYC.
    always_comb begin
        same   = (sync2_q == cand_q);
        cand_d = sync2_q;
        if (!same) begin
            run_d = FILT_ONE;
        end else if (run_q != FILT_MAX) begin
            run_d = run_q + FILT_ONE;
        end else begin
            run_d = run_q;
        end
        accept   = (run_d == FILT_MAX) && !(same && (run_q == FILT_MAX));
        new_code = accept && (sync2_q != acc_code_q);
    end

    assign dec       = decode_code(sync2_q);
    assign dec_valid = dec[3];
    assign dec_idx   = dec[2:0];
    assign diff      = dec_idx - idx_q;
    assign released  = (sync2_q == 4'b0000);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        pulse_d    = 1'b0;
        acc_code_d = new_code ? sync2_q : acc_code_q;

        case (state_q)
            SYNC: begin
                if (new_code && !released) begin
                    if (dec_valid) begin
                        idx_d   = dec_idx;
                        state_d = TRACK;
                    end else begin
                        state_d = FAULT;
                    end
                end
            end
            TRACK: begin
                if (new_code) begin
                    if (released) begin
                        state_d = SYNC;
                    end else if (!dec_valid) begin
                        state_d = FAULT;
                    end else begin
                        case (diff)
                            3'd1: begin
                                pos_d   = pos_q + POS_W'(1);
                                dir_d   = 1'b1;
                                pulse_d = 1'b1;
                                idx_d   = dec_idx;
                            end
                            3'd2: begin
                                pos_d   = pos_q + POS_W'(2);
                                dir_d   = 1'b1;
                                pulse_d = 1'b1;
                                idx_d   = dec_idx;
                            end
                            3'd7: begin
                                pos_d   = pos_q - POS_W'(1);
                                dir_d   = 1'b0;
                                pulse_d = 1'b1;
                                idx_d   = dec_idx;
                            end
                            3'd6: begin
                                pos_d   = pos_q - POS_W'(2);
                                dir_d   = 1'b0;
                                pulse_d = 1'b1;
                                idx_d   = dec_idx;
                            end
                            default: state_d = FAULT;
                        endcase
                    end
                end
            end
            FAULT: begin
                // Any candidate accepted alongside clrErr is dropped here.
                if (clrErr) begin
                    state_d = SYNC;
                end
            end
            default: state_d = SYNC;
        endcase

        err_d = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 4'b0000;
            sync2_q    <= 4'b0000;
            cand_q     <= 4'b0000;
            run_q      <= '0;
            acc_code_q <= 4'b0000;
            state_q    <= SYNC;
            idx_q      <= 3'd0;
            pos_q      <= '0;
            pulse_q    <= 1'b0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= bobinasMotor;
            sync2_q    <= sync1_q;
            cand_q     <= cand_d;
            run_q      <= run_d;
            acc_code_q <= acc_code_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            pos_q      <= pos_d;
            pulse_q    <= pulse_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
        end
    end

    assign posicion   = pos_q;
    assign pulsoPaso  = pulse_q;
    assign direccGiro = dir_q;
    assign ledDirecc  = dir_q;
    assign errorSec   = err_q;

`ifdef PERIOD_MEAS_EN
    logic [23:0] per_cnt_q, per_cnt_d;
    logic [23:0] per_q, per_d;

    // The count on the cycle of a step is the spacing from the previous
    // step, so it is captured before restarting at 1.
    always_comb begin
        per_d     = per_q;
        per_cnt_d = per_cnt_q;
        if (state_d != TRACK) begin
            per_cnt_d = 24'd0;
        end else if (pulse_d) begin
            per_d     = per_cnt_q;
            per_cnt_d = 24'd1;
        end else if ((state_q == TRACK) && (per_cnt_q != 24'hFFFFFF)) begin
            per_cnt_d = per_cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt_q <= 24'd0;
            per_q     <= 24'd0;
        end else begin
            per_cnt_q <= per_cnt_d;
            per_q     <= per_d;
        end
    end

    assign periodoPaso = per_q;
`else
    assign periodoPaso = 24'd0;
`endif

endmodule
